mem_line_bridge: RTL and testbench

MEM_LINE_BRIDGE -- requirements
Module: mem_line_bridge

---
 rtl/mem_line_bridge.sv | 141 ++++++++++++++
 tb/tb_mem_line_bridge.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_bridge.sv
// Splits 128-bit line reads/writes from a cache-side requester into four
// 32-bit word beats on a simple req/ack external port, with a per-beat ack timeout.
module mem_line_bridge #(
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic         mem_ready,
    output logic [127:0] mem_rdata,
    output logic         ext_req,
    output logic         ext_we,
    output logic [29:0]  ext_addr,
    output logic [31:0]  ext_wdata,
    input  logic         ext_ack,
    input  logic [31:0]  ext_rdata,
    output logic         err
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WR_BEAT, RD_BEAT, DONE} state_t;

    state_t              state_q;
    logic [1:0]          beat_q;
    logic [WAIT_W-1:0]   wait_q;
    logic [27:0]         addr_q;
    logic [127:0]        wline_q;
    logic [127:0]        rline_q;
    logic [127:0]        rline_d;
    logic [127:0]        rdata_q;
    logic                ready_q;
    logic                req_q;
    logic                we_q;
    logic                err_q;
    logic                beat_active;
    logic                timeout_hit;

    assign beat_active = (state_q == WR_BEAT) || (state_q == RD_BEAT);
    assign timeout_hit = beat_active && !ext_ack && (wait_q == WAIT_W'(TIMEOUT - 1));

    // Read line with the current beat's word merged in, used on the ack cycle.
    always_comb begin
        rline_d = rline_q;
        for (int k = 0; k < 4; k++) begin
            if (beat_q == 2'(k)) rline_d[32*k +: 32] = ext_rdata;
        end
    end

    always_comb begin
        ext_wdata = wline_q[31:0];
        case (beat_q)
            2'd0: ext_wdata = wline_q[31:0];
            2'd1: ext_wdata = wline_q[63:32];
            2'd2: ext_wdata = wline_q[95:64];
            2'd3: ext_wdata = wline_q[127:96];
            default: ext_wdata = wline_q[31:0];
        endcase
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q <= IDLE;
            beat_q  <= 2'd0;
            wait_q  <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_write) begin
                        addr_q  <= mem_addr;
                        wline_q <= mem_wdata;
                        beat_q  <= 2'd0;
                        wait_q  <= '0;
                        req_q   <= 1'b1;
                        we_q    <= 1'b1;
                        state_q <= WR_BEAT;
                    end else if (mem_read) begin
                        addr_q  <= mem_addr;
                        rline_q <= '0;
                        beat_q  <= 2'd0;
                        wait_q  <= '0;
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                        state_q <= RD_BEAT;
                    end
                end
                WR_BEAT, RD_BEAT: begin
                    if (ext_ack) begin
                        wait_q <= '0;
                        if (state_q == RD_BEAT) rline_q <= rline_d;
                        if (beat_q == 2'd3) begin
                            req_q   <= 1'b0;
                            we_q    <= 1'b0;
                            ready_q <= 1'b1;
                            if (state_q == RD_BEAT) rdata_q <= rline_d;
                            state_q <= DONE;
                        end else begin
                            beat_q <= beat_q + 2'd1;
                        end
                    end else if (timeout_hit) begin
                        // Abort: words never received stay zero from the clear at read start.
                        err_q   <= 1'b1;
                        wait_q  <= '0;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        ready_q <= 1'b1;
                        if (state_q == RD_BEAT) rdata_q <= rline_q;
                        state_q <= DONE;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                DONE: begin
                    beat_q  <= 2'd0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign ext_req   = req_q;
    assign ext_we    = we_q;
    assign ext_addr  = {addr_q, beat_q};
    assign err       = err_q;

endmodule

// File: tb/tb_mem_line_bridge.sv
// Scoreboard bench for mem_line_bridge: directed line transfers, expected beats and
// completions queued at issue time, checked by monitors on the falling edge.
module tb_mem_line_bridge;

    logic         clk = 1'b0;
    logic         proc_reset;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ready;
    logic [127:0] mem_rdata;
    logic         ext_req, ext_we;
    logic [29:0]  ext_addr;
    logic [31:0]  ext_wdata;
    logic         ext_ack;
    logic [31:0]  ext_rdata;
    logic         err;

    mem_line_bridge #(.TIMEOUT(4)) dut (
        .clk(clk), .proc_reset(proc_reset),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .ext_req(ext_req), .ext_we(ext_we),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_ack(ext_ack), .ext_rdata(ext_rdata),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic        chkw;
    } beat_t;

    typedef struct packed {
        logic [127:0] rdata;
        logic         err;
    } done_t;

    beat_t beat_q[$];
    done_t done_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Responder knobs
    int          ack_delay = 0;
    int          stuck_beat = -1;
    logic        spur = 1'b0;
    logic [31:0] rd_tbl [4];
    int          wcnt = 0;

    logic [127:0] exp_line = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // External-port responder: decides ack for the cycle just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (ext_req) begin
            ext_rdata = rd_tbl[ext_addr[1:0]];
            if (wcnt >= ack_delay && !(stuck_beat >= 0 && int'(ext_addr[1:0]) == stuck_beat)) begin
                ext_ack = 1'b1;
                wcnt = 0;
            end else begin
                ext_ack = 1'b0;
                wcnt++;
            end
        end else begin
            ext_ack = spur;
            wcnt = 0;
        end
    end

    // Beat monitor
    always @(negedge clk) begin
        if (ext_req && ext_ack) begin
            if (beat_q.size() == 0) begin
                check("unexpected_beat_addr", {98'd0, ext_addr}, 128'hFFFF);
            end else begin
                beat_t e;
                e = beat_q.pop_front();
                check("beat_we", {127'd0, ext_we}, {127'd0, e.we});
                check("beat_addr", {98'd0, ext_addr}, {98'd0, e.addr});
                if (e.chkw) check("beat_wdata", {96'd0, ext_wdata}, {96'd0, e.wdata});
            end
        end
    end

    // Completion monitor
    always @(negedge clk) begin
        if (mem_ready) begin
            if (done_q.size() == 0) begin
                check("unexpected_mem_ready", 128'd1, 128'd0);
            end else begin
                done_t d;
                d = done_q.pop_front();
                check("mem_rdata", mem_rdata, d.rdata);
                check("err_at_ready", {127'd0, err}, {127'd0, d.err});
            end
        end
    end

    task automatic push_wr(input logic [27:0] a, input logic [127:0] w);
        for (int k = 0; k < 4; k++)
            beat_q.push_back('{we: 1'b1, addr: {a, 2'(k)}, wdata: w[32*k +: 32], chkw: 1'b1});
    endtask

    task automatic push_rd(input logic [27:0] a, input int n);
        for (int k = 0; k < n; k++)
            beat_q.push_back('{we: 1'b0, addr: {a, 2'(k)}, wdata: 32'd0, chkw: 1'b0});
    endtask

    task automatic push_done(input logic [127:0] r, input logic e);
        done_q.push_back('{rdata: r, err: e});
    endtask

    // Issues a request from the current cycle and returns in the mem_ready cycle.
    task automatic xfer(input logic wr, input logic rd, input logic [27:0] a,
                        input logic [127:0] w, output int lat);
        mem_write = wr;
        mem_read  = rd;
        mem_addr  = a;
        mem_wdata = w;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!mem_ready && lat < 200);
        if (!mem_ready) check("xfer_timeout", 128'd0, 128'd1);
    endtask

    task automatic idle_inputs();
        mem_write = 1'b0;
        mem_read  = 1'b0;
    endtask

    initial begin
        int lat;
        logic [127:0] w;
        proc_reset = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
        ext_ack = 1'b0; ext_rdata = '0;
        for (int k = 0; k < 4; k++) rd_tbl[k] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_ready", {127'd0, mem_ready}, 128'd0);
        check("rst_ext_req", {127'd0, ext_req}, 128'd0);
        check("rst_ext_we", {127'd0, ext_we}, 128'd0);
        check("rst_err", {127'd0, err}, 128'd0);
        check("rst_mem_rdata", mem_rdata, 128'd0);
        check("rst_ext_addr", {98'd0, ext_addr}, 128'd0);
        check("rst_ext_wdata", {96'd0, ext_wdata}, 128'd0);
        proc_reset = 1'b0;

        // Single write, ack tied high: minimum latency
        w = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        ack_delay = 0;
        push_wr(28'h0000012, w);
        push_done(exp_line, 1'b0);
        xfer(1'b1, 1'b0, 28'h0000012, w, lat);
        check("wr_latency", 128'(lat), 128'd5);
        idle_inputs();
        repeat (2) @(posedge clk); #1;

        // Read with two-cycle ack delay per beat
        rd_tbl[0] = 32'h11; rd_tbl[1] = 32'h22; rd_tbl[2] = 32'h33; rd_tbl[3] = 32'h44;
        ack_delay = 2;
        push_rd(28'h0ABCDEF, 4);
        exp_line = {32'h44, 32'h33, 32'h22, 32'h11};
        push_done(exp_line, 1'b0);
        xfer(1'b0, 1'b1, 28'h0ABCDEF, '0, lat);
        check("rd_latency", 128'(lat), 128'd13);
        idle_inputs();
        @(posedge clk); #1;

        // Write-back then refill, switched in the mem_ready cycle
        ack_delay = 0;
        w = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
        rd_tbl[0] = 32'h55; rd_tbl[1] = 32'h66; rd_tbl[2] = 32'h77; rd_tbl[3] = 32'h88;
        push_wr(28'h0000100, w);
        push_done(exp_line, 1'b0);
        push_rd(28'h0000200, 4);
        push_done({32'h88, 32'h77, 32'h66, 32'h55}, 1'b0);
        xfer(1'b1, 1'b0, 28'h0000100, w, lat);
        xfer(1'b0, 1'b1, 28'h0000200, '0, lat);
        check("refill_latency", 128'(lat), 128'd6);
        exp_line = {32'h88, 32'h77, 32'h66, 32'h55};
        idle_inputs();
        @(posedge clk); #1;

        // Read and write together: write wins
        w = 128'hCAFEF00D_BEEF0003_BEEF0002_BEEF0001;
        push_wr(28'h1234567, w);
        push_done(exp_line, 1'b0);
        xfer(1'b1, 1'b1, 28'h1234567, w, lat);
        idle_inputs();
        @(posedge clk); #1;

        // Acks while idle are ignored
        spur = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("spur_ready", {127'd0, mem_ready}, 128'd0);
        check("spur_ext_req", {127'd0, ext_req}, 128'd0);
        @(posedge clk); #1;
        spur = 1'b0;
        @(posedge clk); #1;

        // Timeout on beat 1 of a read
        rd_tbl[0] = 32'hAA; rd_tbl[1] = 32'hBB; rd_tbl[2] = 32'hCC; rd_tbl[3] = 32'hDD;
        stuck_beat = 1;
        push_rd(28'h0000F00, 1);
        exp_line = {96'd0, 32'hAA};
        push_done(exp_line, 1'b1);
        xfer(1'b0, 1'b1, 28'h0000F00, '0, lat);
        check("timeout_latency", 128'(lat), 128'd6);
        idle_inputs();
        stuck_beat = -1;
        @(posedge clk); #1;

        // Normal read after the error; err stays sticky
        rd_tbl[0] = 32'h1; rd_tbl[1] = 32'h2; rd_tbl[2] = 32'h3; rd_tbl[3] = 32'h4;
        push_rd(28'h0000001, 4);
        exp_line = {32'h4, 32'h3, 32'h2, 32'h1};
        push_done(exp_line, 1'b1);
        xfer(1'b0, 1'b1, 28'h0000001, '0, lat);
        idle_inputs();
        @(posedge clk); #1;

        // Reset during beat 2 of a write
        ack_delay = 1;
        w = 128'h44444444_33333333_22222222_11111111;
        beat_q.push_back('{we: 1'b1, addr: {28'h0000020, 2'd0}, wdata: 32'h11111111, chkw: 1'b1});
        beat_q.push_back('{we: 1'b1, addr: {28'h0000020, 2'd1}, wdata: 32'h22222222, chkw: 1'b1});
        mem_write = 1'b1; mem_addr = 28'h0000020; mem_wdata = w;
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_beat2_addr", {98'd0, ext_addr}, {98'd0, 28'h0000020, 2'd2});
        proc_reset = 1'b1;
        #1;
        check("midrst_ext_req", {127'd0, ext_req}, 128'd0);
        check("midrst_err", {127'd0, err}, 128'd0);
        check("midrst_mem_rdata", mem_rdata, 128'd0);
        mem_write = 1'b0;
        exp_line = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ack_delay = 0;
        proc_reset = 1'b0;
        push_wr(28'h0000020, w);
        push_done(exp_line, 1'b0);
        xfer(1'b1, 1'b0, 28'h0000020, w, lat);
        check("post_rst_latency", 128'(lat), 128'd5);
        idle_inputs();

        // Drain
        for (int i = 0; i < 50 && (beat_q.size() != 0 || done_q.size() != 0); i++)
            @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("beats_left", 128'(beat_q.size()), 128'd0);
        check("dones_left", 128'(done_q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
